// File: rtl/picoblaze_axi4lite_mailbox.sv
// picoblaze_axi4lite_mailbox: AXI4-Lite slave mailbox of 6 words plus two doorbells, shared with a PicoBlaze port space.
module picoblaze_axi4lite_mailbox #(
    parameter int         C_AXI_ADDR_WIDTH = 5,
    parameter int         C_AXI_DATA_WIDTH = 32,
    parameter logic [7:0] C_BASE_ADDRESS   = 8'h60
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    input  logic [7:0]                    port_id,
    input  logic [7:0]                    out_port,
    input  logic                          write_strobe,
    input  logic                          read_strobe,
    output logic [7:0]                    in_port,
    output logic                          interrupt,
    output logic                          host_irq
);
    logic [7:0]                    mem_q [24];
    logic [7:0]                    mem_d [24];
    logic                          aw_pending_q, aw_pending_d, w_pending_q, w_pending_d;
    logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic                          host_db_q, host_db_d, pb_db_q, pb_db_d;
    logic [2:0]                    aw_addr_q, aw_addr_d, rd_idx;
    logic [C_AXI_DATA_WIDTH-1:0]   w_data_q, w_data_d, rdata_q, rdata_d, rd_word;
    logic [C_AXI_DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic [4:0]                    pb_idx;
    logic                          pb_sel, pb_we, commit, db_bit, unused_ok;

    assign pb_idx    = port_id[4:0];
    assign pb_sel    = port_id[7:5] == C_BASE_ADDRESS[7:5];
    assign pb_we     = write_strobe & pb_sel;
    assign commit    = aw_pending_q & w_pending_q & ~bvalid_q;
    assign db_bit    = w_strb_q[0] & w_data_q[0];
    assign rd_idx    = s_axi_araddr[4:2];
    assign rd_word   = rd_idx < 3'd6 ? {mem_q[{rd_idx, 2'd3}], mem_q[{rd_idx, 2'd2}], mem_q[{rd_idx, 2'd1}], mem_q[{rd_idx, 2'd0}]}
                     : rd_idx == 3'd6 ? {31'd0, host_db_q} : {31'd0, pb_db_q};
    assign in_port   = !pb_sel ? 8'h00 : pb_idx < 5'd24 ? mem_q[pb_idx]
                     : pb_idx == 5'd24 ? {7'd0, host_db_q} : pb_idx == 5'd28 ? {7'd0, pb_db_q} : 8'h00;
    assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, read_strobe};

    assign s_axi_awready = ~aw_pending_q;
    assign s_axi_wready  = ~w_pending_q;
    assign s_axi_arready = ~rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign interrupt     = host_db_q;
    assign host_irq      = pb_db_q;

    always_comb begin
        mem_d        = mem_q;
        aw_pending_d = aw_pending_q;
        aw_addr_d    = aw_addr_q;
        w_pending_d  = w_pending_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q & ~s_axi_bready;
        rvalid_d     = rvalid_q & ~s_axi_rready;
        rdata_d      = rdata_q;
        host_db_d    = host_db_q;
        pb_db_d      = pb_db_q;
        if (s_axi_awvalid && !aw_pending_q) begin
            aw_pending_d = 1'b1;
            aw_addr_d    = s_axi_awaddr[4:2];
        end
        if (s_axi_wvalid && !w_pending_q) begin
            w_pending_d = 1'b1;
            w_data_d    = s_axi_wdata;
            w_strb_d    = s_axi_wstrb;
        end
        if (commit) begin
            aw_pending_d = 1'b0;
            w_pending_d  = 1'b0;
            bvalid_d     = 1'b1;
            for (int b = 0; b < 4; b++)
                if (w_strb_q[b] && aw_addr_q < 3'd6) mem_d[{aw_addr_q, 2'(b)}] = w_data_q[8*b +: 8];
            if (aw_addr_q == 3'd7 && db_bit) pb_db_d = 1'b0;
        end
        // PB writes are applied after the AXI commit so the PB value wins on a shared byte; doorbell sets go last
        if (pb_we && pb_idx < 5'd24) mem_d[pb_idx] = out_port;
        if (pb_we && pb_idx == 5'd24 && out_port[0]) host_db_d = 1'b0;
        if (commit && aw_addr_q == 3'd6 && db_bit) host_db_d = 1'b1;
        if (pb_we && pb_idx == 5'd28 && out_port[0]) pb_db_d = 1'b1;
        if (s_axi_arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            mem_q        <= '{default: 8'h00};
            aw_pending_q <= 1'b0;
            aw_addr_q    <= '0;
            w_pending_q  <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            host_db_q    <= 1'b0;
            pb_db_q      <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            aw_pending_q <= aw_pending_d;
            aw_addr_q    <= aw_addr_d;
            w_pending_q  <= w_pending_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            host_db_q    <= host_db_d;
            pb_db_q      <= pb_db_d;
        end
    end
endmodule

// File: tb/tb_picoblaze_axi4lite_mailbox.sv
// tb_picoblaze_axi4lite_mailbox: directed and randomized checks of the mailbox against a byte-array model.
module tb_picoblaze_axi4lite_mailbox;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1, arvalid = 0, arready, rvalid, rready = 1;
    logic [4:0]  awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp, rresp;
    logic [7:0]  port_id = 0, out_port = 0, in_port;
    logic        write_strobe = 0, read_strobe = 0, interrupt, host_irq;
    int          checks = 0, errors = 0;
    logic [7:0]  m [24];
    logic        hdb, pdb;

    always #5 clk = ~clk;

    picoblaze_axi4lite_mailbox dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe), .read_strobe(read_strobe),
        .in_port(in_port), .interrupt(interrupt), .host_irq(host_irq)
    );

    task automatic model_reset;
        for (int i = 0; i < 24; i++) m[i] = 8'h00;
        hdb = 0;
        pdb = 0;
    endtask

    task automatic model_axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int w = int'(a[4:2]);
        if (w < 6) begin
            for (int b = 0; b < 4; b++) if (s[b]) m[w*4+b] = d[8*b +: 8];
        end else if (s[0] && d[0]) begin
            if (w == 6) hdb = 1; else pdb = 0;
        end
    endtask

    task automatic model_pb_write(input logic [7:0] p, input logic [7:0] v);
        int i = int'(p[4:0]);
        if (p[7:5] != 3'b011) return;
        if (i < 24) m[i] = v;
        else if (i == 24 && v[0]) hdb = 0;
        else if (i == 28 && v[0]) pdb = 1;
    endtask

    function automatic logic [31:0] exp_word(input int w);
        if (w < 6) return {m[w*4+3], m[w*4+2], m[w*4+1], m[w*4]};
        return w == 6 ? {31'd0, hdb} : {31'd0, pdb};
    endfunction

    function automatic logic [7:0] exp_port(input logic [7:0] p);
        int i = int'(p[4:0]);
        if (p[7:5] != 3'b011) return 8'h00;
        if (i < 24) return m[i];
        return i == 24 ? {7'd0, hdb} : i == 28 ? {7'd0, pdb} : 8'h00;
    endfunction

    task automatic axi_hs(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic ah, wh;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 40 && (awvalid || wvalid); i++) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(posedge clk); #1;
            if (ah) awvalid = 0;
            if (wh) wvalid = 0;
        end
        if (awvalid || wvalid) begin
            checks++; errors++;
            $display("FAIL aw_w_handshake: awvalid=%0b wvalid=%0b still pending, required accepted", awvalid, wvalid);
            awvalid = 0; wvalid = 0;
        end
    endtask

    task automatic wait_b;
        int n = 0;
        while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL b_response: bvalid=%b bresp=%b, required 1/00", bvalid, bresp);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        axi_hs(a, d, s);
        wait_b();
        model_axi_write(a, d, s);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1;
        while (!arready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
        d = rvalid ? rdata : 32'hxxxxxxxx;
        @(posedge clk); #1;
    endtask

    task automatic pb_write(input logic [7:0] p, input logic [7:0] v);
        port_id = p; out_port = v; write_strobe = 1;
        @(posedge clk); #1;
        write_strobe = 0;
        model_pb_write(p, v);
    endtask

    task automatic test_reset;
        port_id = 8'h64; #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, interrupt, host_irq} !== 7'b1110000 || rdata !== 0 || in_port !== 0) begin
            errors++;
            $display("FAIL reset_state: aw/w/ar/b/r/int/irq=%b rdata=%h in_port=%h, required 1110000/0/0",
                     {awready, wready, arready, bvalid, rvalid, interrupt, host_irq}, rdata, in_port);
        end
    endtask

    task automatic test_w_first;
        wdata = 32'hAABBCCDD; wstrb = 4'b0010; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wready !== 0 || awready !== 1 || bvalid !== 0) begin
                errors++;
                $display("FAIL w_first_wait: wready=%b awready=%b bvalid=%b, required 0/1/0", wready, awready, bvalid);
            end
            @(posedge clk); #1;
        end
        awaddr = 5'h00; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        checks++;
        if (bvalid !== 0) begin errors++; $display("FAIL w_first_bvalid_early: bvalid=%b, required 0", bvalid); end
        @(posedge clk); #1;
        checks++;
        if (bvalid !== 1) begin errors++; $display("FAIL w_first_bvalid: bvalid=%b, required 1", bvalid); end
        @(posedge clk); #1;
        model_axi_write(5'h00, 32'hAABBCCDD, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            port_id = 8'h60 + 8'(i); #1;
            checks++;
            if (in_port !== (i == 1 ? 8'hCC : 8'h00)) begin
                errors++;
                $display("FAIL w_first_byte%0d: in_port=%h, required %h", i, in_port, i == 1 ? 8'hCC : 8'h00);
            end
        end
    endtask

    task automatic test_basic_write;
        logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        axi_hs(5'h04, 32'h11223344, 4'hF);
        checks++;
        if (bvalid !== 0) begin errors++; $display("FAIL basic_bvalid_early: bvalid=%b, required 0", bvalid); end
        @(posedge clk); #1;
        checks++;
        if (bvalid !== 1 || bresp !== 2'b00) begin
            errors++; $display("FAIL basic_bvalid: bvalid=%b bresp=%b, required 1/00", bvalid, bresp);
        end
        @(posedge clk); #1;
        checks++;
        if (bvalid !== 0) begin errors++; $display("FAIL basic_bvalid_clear: bvalid=%b, required 0", bvalid); end
        model_axi_write(5'h04, 32'h11223344, 4'hF);
        for (int i = 0; i < 4; i++) begin
            port_id = 8'h64 + 8'(i); #1;
            checks++;
            if (in_port !== exp[i]) begin
                errors++; $display("FAIL basic_pb_read%0d: in_port=%h, required %h", i, in_port, exp[i]);
            end
        end
    endtask

    task automatic test_doorbells;
        logic [31:0] d;
        axi_write(5'h18, 32'h1, 4'h1);
        checks++;
        if (interrupt !== 1) begin errors++; $display("FAIL db_host_set: interrupt=%b, required 1", interrupt); end
        pb_write(8'h78, 8'h01);
        checks++;
        if (interrupt !== 0) begin errors++; $display("FAIL db_host_clear: interrupt=%b, required 0", interrupt); end
        axi_hs(5'h18, 32'h1, 4'h1);
        port_id = 8'h78; out_port = 8'h01; write_strobe = 1;
        @(posedge clk); #1;
        write_strobe = 0;
        model_pb_write(8'h78, 8'h01);
        model_axi_write(5'h18, 32'h1, 4'h1);
        checks++;
        if (interrupt !== 1 || bvalid !== 1) begin
            errors++; $display("FAIL db_set_wins: interrupt=%b bvalid=%b, required 1/1", interrupt, bvalid);
        end
        @(posedge clk); #1;
        pb_write(8'h7C, 8'h01);
        checks++;
        if (host_irq !== 1) begin errors++; $display("FAIL db_pb_set: host_irq=%b, required 1", host_irq); end
        axi_read(5'h1C, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL db_pb_read: rdata=%h, required 00000001", d); end
        axi_write(5'h1C, 32'h1, 4'h1);
        checks++;
        if (host_irq !== 0) begin errors++; $display("FAIL db_pb_clear: host_irq=%b, required 0", host_irq); end
    endtask

    task automatic test_bready_stall;
        logic [7:0] old;
        bready = 0;
        axi_hs(5'h00, 32'h0BADF00D, 4'hF);
        model_axi_write(5'h00, 32'h0BADF00D, 4'hF);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bvalid !== 1 || awready !== 1) begin
                errors++; $display("FAIL stall_hold%0d: bvalid=%b awready=%b, required 1/1", i, bvalid, awready);
            end
            @(posedge clk); #1;
        end
        old = m[4];
        axi_hs(5'h04, 32'h5566778F, 4'hF);
        for (int i = 0; i < 3; i++) begin
            port_id = 8'h64; @(posedge clk); #1;
            checks++;
            if (in_port !== old || bvalid !== 1) begin
                errors++; $display("FAIL stall_no_commit: in_port=%h bvalid=%b, required %h/1", in_port, bvalid, old);
            end
        end
        bready = 1;
        @(posedge clk); #1;
        checks++;
        if (bvalid !== 0) begin errors++; $display("FAIL stall_b_done: bvalid=%b, required 0", bvalid); end
        wait_b();
        model_axi_write(5'h04, 32'h5566778F, 4'hF);
        port_id = 8'h64; #1;
        checks++;
        if (in_port !== 8'h8F) begin errors++; $display("FAIL stall_second_commit: in_port=%h, required 8f", in_port); end
    endtask

    task automatic test_conflicts;
        logic [31:0] old, d;
        old = exp_word(2);
        axi_hs(5'h08, 32'hDEADBEEF, 4'hF);
        port_id = 8'h69; out_port = 8'h5A; write_strobe = 1;
        araddr = 5'h08; arvalid = 1;
        @(posedge clk); #1;
        write_strobe = 0; arvalid = 0;
        checks++;
        if (rvalid !== 1 || rdata !== old || bvalid !== 1) begin
            errors++; $display("FAIL conflict_read_old: rvalid=%b rdata=%h bvalid=%b, required 1/%h/1", rvalid, rdata, bvalid, old);
        end
        @(posedge clk); #1;
        model_axi_write(5'h08, 32'hDEADBEEF, 4'hF);
        model_pb_write(8'h69, 8'h5A);
        axi_read(5'h08, d);
        checks++;
        if (d !== 32'hDEAD5AEF || d !== exp_word(2)) begin
            errors++; $display("FAIL conflict_pb_wins: rdata=%h, required deAD5aef", d);
        end
    endtask

    task automatic test_random;
        logic [31:0] d, dd;
        logic [7:0]  p;
        logic [4:0]  a;
        for (int it = 0; it < 80; it++) begin
            a = {3'($urandom_range(0, 7)), 2'b00};
            p = $urandom_range(0, 1) ? {3'b011, 5'($urandom)} : 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    d = $urandom;
                    axi_write(a, d, 4'($urandom));
                end
                1: pb_write(p, 8'($urandom));
                2: begin
                    axi_read(a, d);
                    dd = exp_word(int'(a[4:2]));
                    checks++;
                    if (d !== dd) begin errors++; $display("FAIL rand_axi_read@%h: rdata=%h, required %h", a, d, dd); end
                end
                default: begin
                    port_id = p; #1;
                    checks++;
                    if (in_port !== exp_port(p)) begin
                        errors++; $display("FAIL rand_pb_read@%h: in_port=%h, required %h", p, in_port, exp_port(p));
                    end
                end
            endcase
            checks++;
            if (interrupt !== hdb || host_irq !== pdb) begin
                errors++; $display("FAIL rand_flags: interrupt=%b host_irq=%b, required %b/%b", interrupt, host_irq, hdb, pdb);
            end
        end
    endtask

    task automatic test_async_reset;
        pb_write(8'h7C, 8'h01);
        axi_write(5'h18, 32'h1, 4'h1);
        pb_write(8'h64, 8'hA5);
        rready = 0;
        araddr = 5'h04; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0;
        checks++;
        if (rvalid !== 1 || wready !== 0 || interrupt !== 1 || host_irq !== 1) begin
            errors++; $display("FAIL arst_setup: rvalid=%b wready=%b int=%b irq=%b, required 1/0/1/1", rvalid, wready, interrupt, host_irq);
        end
        port_id = 8'h64;
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({rvalid, bvalid, awready, wready, arready, interrupt, host_irq} !== 7'b0011100 || rdata !== 0 || in_port !== 0) begin
            errors++;
            $display("FAIL arst_outputs: r/b/aw/w/ar/int/irq=%b rdata=%h in_port=%h, required 0011100/0/0",
                     {rvalid, bvalid, awready, wready, arready, interrupt, host_irq}, rdata, in_port);
        end
        @(posedge clk); #1;
        rst_n = 1; rready = 1;
        awaddr = 5'h04; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bvalid !== 0) begin errors++; $display("FAIL arst_w_dropped: bvalid=%b, required 0", bvalid); end
        wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0;
        wait_b();
        model_axi_write(5'h04, 32'hCAFE0001, 4'hF);
        port_id = 8'h65; #1;
        checks++;
        if (in_port !== 8'h00) begin errors++; $display("FAIL arst_post_write: in_port=%h, required 00", in_port); end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_w_first();
        test_basic_write();
        test_doorbells();
        test_bready_stall();
        test_conflicts();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
